// File: rtl/waveform_generator.sv
// Multi-mode waveform source: phase accumulator -> shape -> amplitude scaler, with
// period-boundary config updates. Define WAVEGEN_OFFSET_EN to add a saturating Offset input.
module waveform_generator #(
  parameter int DATA_W  = 14,
  parameter int PHASE_W = 16
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Enable,
  input  logic               Load,
  input  logic [1:0]         Mode,
  input  logic [PHASE_W-1:0] PhaseInc,
  input  logic [PHASE_W-1:0] Duty,
  input  logic [DATA_W-1:0]  Amplitude,
`ifdef WAVEGEN_OFFSET_EN
  input  logic [DATA_W:0]    Offset,
`endif
  output logic [DATA_W-1:0]  SignalOut,
  output logic               Valid,
  output logic               PeriodStart,
  output logic               Busy,
  output logic [1:0]         debug_state
);

  // Valid/PeriodStart semantics: Valid is high for every cycle SignalOut carries a
  // generated sample; there is no backpressure, so each Valid cycle is one sample.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]         mode;
    logic [PHASE_W-1:0] inc;
    logic [PHASE_W-1:0] duty;
    logic [DATA_W-1:0]  amp;
`ifdef WAVEGEN_OFFSET_EN
    logic [DATA_W:0]    offset;
`endif
  } cfg_t;

  localparam logic [PHASE_W-1:0] HALF_PHASE = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic [2*DATA_W:0]  MAX_W      = {{(DATA_W+1){1'b0}}, {DATA_W{1'b1}}};

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic               first;
  logic               pending;
  cfg_t               act;
  cfg_t               shadow;
  cfg_t               cfg_in;
  cfg_t               cfg_default;

  logic               generating;
  logic [PHASE_W:0]   phase_sum;
  logic               wrap;
  logic [DATA_W-1:0]  shape;
  logic [DATA_W:0]    amp_p1;
  logic [2*DATA_W:0]  product;
  logic [2*DATA_W:0]  scaled_w;
  logic [DATA_W-1:0]  sample_next;

  always_comb begin
    cfg_in        = '0;
    cfg_in.mode   = Mode;
    cfg_in.inc    = PhaseInc;
    cfg_in.duty   = Duty;
    cfg_in.amp    = Amplitude;
`ifdef WAVEGEN_OFFSET_EN
    cfg_in.offset = Offset;
`endif
  end

  always_comb begin
    cfg_default      = '0;
    cfg_default.inc  = HALF_PHASE;
    cfg_default.duty = HALF_PHASE;
    cfg_default.amp  = '1;
  end

  assign generating  = (state != IDLE);
  assign phase_sum   = {1'b0, phase} + {1'b0, act.inc};
  assign wrap        = generating & phase_sum[PHASE_W];
  assign debug_state = state;

  always_comb begin
    shape = '0;
    case (act.mode)
      2'b00:   shape = (phase < act.duty) ? '1 : '0;
      2'b01:   shape = phase[PHASE_W-1 -: DATA_W];
      2'b10:   shape = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: DATA_W]
                                        :  phase[PHASE_W-2 -: DATA_W];
      default: shape = '1;
    endcase
  end

  // Multiplying by Amplitude+1 lets all-ones pass the shape through unchanged.
  assign amp_p1   = {1'b0, act.amp} + {{DATA_W{1'b0}}, 1'b1};
  assign product  = {{(DATA_W+1){1'b0}}, shape} * {{DATA_W{1'b0}}, amp_p1};
  assign scaled_w = product >> DATA_W;

`ifdef WAVEGEN_OFFSET_EN
  logic [2*DATA_W+1:0] off_ext;
  logic [2*DATA_W+1:0] off_sum;
  assign off_ext = {{(DATA_W+1){act.offset[DATA_W]}}, act.offset};
  assign off_sum = {1'b0, scaled_w} + off_ext;

  always_comb begin
    sample_next = off_sum[DATA_W-1:0];
    if (off_sum[2*DATA_W+1])
      sample_next = '0;
    else if (off_sum[2*DATA_W:0] > MAX_W)
      sample_next = '1;
  end
`else
  always_comb begin
    sample_next = scaled_w[DATA_W-1:0];
    if (scaled_w > MAX_W)
      sample_next = '1;
  end
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      phase       <= '0;
      first       <= 1'b0;
      pending     <= 1'b0;
      act         <= cfg_default;
      shadow      <= cfg_default;
      SignalOut   <= '0;
      Valid       <= 1'b0;
      PeriodStart <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      if (generating) begin
        SignalOut   <= sample_next;
        Valid       <= 1'b1;
        PeriodStart <= first;
      end else begin
        SignalOut   <= '0;
        Valid       <= 1'b0;
        PeriodStart <= 1'b0;
      end

      case (state)
        IDLE: begin
          phase   <= '0;
          pending <= 1'b0;
          first   <= Enable;
          if (Load) begin
            act    <= cfg_in;
            shadow <= cfg_in;
          end else if (pending) begin
            act <= shadow;
          end
          if (Enable) begin
            state <= RUN;
            Busy  <= 1'b1;
          end
        end
        default: begin
          phase <= phase_sum[PHASE_W-1:0];
          first <= wrap;
          // A Load landing on the wrap edge bypasses the shadow entirely.
          if (Load && wrap) begin
            act     <= cfg_in;
            pending <= 1'b0;
          end else if (Load) begin
            shadow  <= cfg_in;
            pending <= 1'b1;
          end else if (wrap && pending) begin
            act     <= shadow;
            pending <= 1'b0;
          end
          if (Enable) begin
            state <= RUN;
          end else if (state == RUN) begin
            state <= STOPPING;
          end else if (wrap || (act.inc == '0)) begin
            state <= IDLE;
            Busy  <= 1'b0;
            phase <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_generator.sv
// Randomised bench for waveform_generator: a period-level reference model pushes the
// expected per-cycle output into a queue that a negedge monitor pops and compares.
module tb_waveform_generator;
  localparam int DATA_W  = 14;
  localparam int PHASE_W = 16;
  localparam int FULL    = (1 << DATA_W) - 1;
  localparam int HALF    = 1 << (PHASE_W - 1);
  localparam int PMOD    = 1 << PHASE_W;
  localparam int EW      = DATA_W + 3;

  logic               Clock = 1'b0;
  logic               Reset_n = 1'b0;
  logic               Enable = 1'b0;
  logic               Load = 1'b0;
  logic [1:0]         mode = '0;
  logic [PHASE_W-1:0] phase_inc = '0;
  logic [PHASE_W-1:0] duty = '0;
  logic [DATA_W-1:0]  amplitude = '0;
  logic [DATA_W:0]    offset = '0;
  logic [DATA_W-1:0]  signal_out;
  logic               valid;
  logic               period_start;
  logic               busy;
  logic [1:0]         debug_state;

  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;

  logic [EW-1:0] exp_q[$];

  waveform_generator #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .Enable(Enable),
    .Load(Load),
    .Mode(mode),
    .PhaseInc(phase_inc),
    .Duty(duty),
    .Amplitude(amplitude),
`ifdef WAVEGEN_OFFSET_EN
    .Offset(offset),
`endif
    .SignalOut(signal_out),
    .Valid(valid),
    .PeriodStart(period_start),
    .Busy(busy),
    .debug_state(debug_state)
  );

  // clock / reset
  always #10 Clock = ~Clock;

  // reference model
  typedef struct {
    int mode;
    int inc;
    int duty;
    int amp;
    int off;
  } cfg_t;

  localparam cfg_t DEF = '{0, HALF, HALF, FULL, 0};

  cfg_t m_act, m_shd;
  bit   m_run, m_stop, m_first, m_pend;
  int   m_phase;

  function automatic int out_of(cfg_t c, int p);
    int s;
    longint v;
    case (c.mode)
      0: s = (p < c.duty) ? FULL : 0;
      1: s = p / (1 << (PHASE_W - DATA_W));
      2: begin
        s = (p % HALF) / (1 << (PHASE_W - 1 - DATA_W));
        if (p >= HALF) s = FULL - s;
      end
      default: s = FULL;
    endcase
    v = (longint'(s) * longint'(c.amp + 1)) / (longint'(1) << DATA_W);
`ifdef WAVEGEN_OFFSET_EN
    v = v + c.off;
    if (v < 0) v = 0;
    if (v > FULL) v = FULL;
`endif
    return int'(v);
  endfunction

  always @(posedge Clock or negedge Reset_n) begin
    cfg_t cin;
    int   sum, old_inc, e_data;
    bit   wrapped, gen, e_start;
    if (!Reset_n) begin
      m_run = 0; m_stop = 0; m_first = 0; m_pend = 0; m_phase = 0;
      m_act = DEF; m_shd = DEF;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      cin = '{int'(mode), int'(phase_inc), int'(duty), int'(amplitude), int'($signed(offset))};
      gen = m_run || m_stop;
      e_data = gen ? out_of(m_act, m_phase) : 0;
      e_start = gen && m_first;
      if (!gen) begin
        m_phase = 0;
        m_first = Enable;
        if (Load) begin m_act = cin; m_shd = cin; end
        else if (m_pend) m_act = m_shd;
        m_pend = 0;
        m_run = Enable;
      end else begin
        old_inc = m_act.inc;
        sum = m_phase + old_inc;
        wrapped = (sum >= PMOD);
        m_phase = sum % PMOD;
        m_first = wrapped;
        if (Load && wrapped) begin m_act = cin; m_pend = 0; end
        else if (Load) begin m_shd = cin; m_pend = 1; end
        else if (wrapped && m_pend) begin m_act = m_shd; m_pend = 0; end
        if (Enable) begin m_run = 1; m_stop = 0; end
        else if (m_run) begin m_run = 0; m_stop = 1; end
        else if (wrapped || old_inc == 0) begin m_stop = 0; m_phase = 0; end
      end
      exp_q.push_back({(m_run || m_stop), gen, e_start, DATA_W'(e_data)});
    end
  end

  // scoreboard monitor
  always @(negedge Clock) begin
    logic [EW-1:0] got, exp_v;
    if (mon_en) begin
      got = {busy, valid, period_start, signal_out};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sample: no expectation queued, got busy/valid/start/data %b/%b/%b/%h",
                 busy, valid, period_start, signal_out);
      end else begin
        exp_v = exp_q.pop_front();
        if (got === exp_v) passes++;
        else $display("FAIL sample t=%0t: got busy/valid/start/data %b/%b/%b/%h, want %b/%b/%b/%h",
                      $time, got[EW-1], got[EW-2], got[EW-3], got[DATA_W-1:0],
                      exp_v[EW-1], exp_v[EW-2], exp_v[EW-3], exp_v[DATA_W-1:0]);
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic load_cfg(input int m, input int inc, input int d, input int a, input int o);
    @(negedge Clock);
    Load = 1'b1;
    mode = 2'(m);
    phase_inc = PHASE_W'(inc);
    duty = PHASE_W'(d);
    amplitude = DATA_W'(a);
    offset = (DATA_W+1)'(o);
    @(negedge Clock);
    Load = 1'b0;
  endtask

  task automatic load_random();
    int inc_sel, amp_sel;
    inc_sel = $urandom_range(0, 4);
    amp_sel = $urandom_range(0, 3);
    load_cfg($urandom_range(0, 3),
             (inc_sel == 0) ? 0 : (inc_sel == 1) ? 'h8000 : (inc_sel == 2) ? 'h0400 :
             (inc_sel == 3) ? 'h4000 : $urandom_range('h100, 'hFFFF),
             ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, PMOD - 1),
             (amp_sel == 0) ? 0 : (amp_sel == 1) ? FULL : $urandom_range(0, FULL),
             $urandom_range(0, 2 * FULL + 1) - (FULL + 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    Enable = 1'b0;
    @(negedge Clock);
    while (busy && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (!busy) passes++;
    else $display("FAIL idle_timeout: busy still %b after %0d cycles, want 0", busy, n);
  endtask

  initial begin
    @(posedge Clock);
    #1 mon_en = 1'b1;
    cycles(3);
    Reset_n = 1'b1;
    cycles(2);

    // reset defaults: 50% square at Fclk/2
    Enable = 1'b1;
    cycles(12);
    wait_idle();

    // sawtooth ramp, 64-sample period
    load_cfg(1, 'h0400, 0, FULL, 0);
    Enable = 1'b1;
    cycles(140);
    // triangle queued mid-period, applied at the next wrap
    load_cfg(2, 'h0800, 0, 'h1FFF, 0);
    cycles(80);
    // 25% square queued mid-period
    load_cfg(0, 'h0400, 'h4000, FULL, 0);
    cycles(100);
    wait_idle();

    // period of two cycles: back-to-back loads land on wrap edges
    load_cfg(0, 'h8000, 'h4000, 'h2AAA, 0);
    Enable = 1'b1;
    for (int i = 0; i < 10; i++)
      load_cfg($urandom_range(0, 3), 'h8000, $urandom_range(0, PMOD - 1), $urandom_range(0, FULL), 0);
    cycles(5);
    wait_idle();

    // PhaseInc = 0: stops one cycle after Enable drops
    load_cfg(3, 0, 0, 'h1234, 0);
    Enable = 1'b1;
    cycles(4);
    wait_idle();

    // randomised run
    Enable = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) Enable = ~Enable;
      if ($urandom_range(0, 9) == 0) load_random();
      else @(negedge Clock);
    end
    wait_idle();

    // asynchronous reset mid-run restores defaults
    load_cfg(1, 'h0400, 0, 'h1000, 0);
    Enable = 1'b1;
    cycles(7);
    @(posedge Clock);
    #3 Reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, valid, period_start, signal_out, debug_state} === '0) passes++;
    else $display("FAIL async_reset: got busy/valid/start/data/state %b/%b/%b/%h/%0d, want all 0",
                  busy, valid, period_start, signal_out, debug_state);
    @(negedge Clock);
    Enable = 1'b0;
    cycles(2);
    Reset_n = 1'b1;
    Enable = 1'b1;
    cycles(8);
    wait_idle();

`ifdef WAVEGEN_OFFSET_EN
    // DC full scale plus positive offset saturates
    load_cfg(3, 'h1000, 0, FULL, 'h100);
    Enable = 1'b1;
    cycles(6);
    load_cfg(1, 'h0400, 0, 'h0800, -'h80);
    cycles(80);
    wait_idle();
`endif

    cycles(2);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
